pipe_ctrl: RTL and testbench

Central pipeline stall/flush sequencer for the 5-stage MIPS core. It detects load-use hazards that the ID forwarding paths cannot cover and sequences multi-cycle EX operations (DIV/DIVU, MULT) through a start/done handshake with a timeout. It arbitrates these against flush requests and drives the per-stage stall vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_luse.sv | 23 ++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stall bit
// positions, canned stall patterns and FSM state encodings.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LUSE = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_luse.sv
// Load-use hazard detector: flags an ID operand that depends on a load
// still in EX, which the ID forwarding paths cannot supply yet.
module pipe_ctrl_luse
  import pipe_ctrl_pkg::*;
(
  input  logic       id_reg1_read,
  input  logic [4:0] id_reg1_addr,
  input  logic       id_reg2_read,
  input  logic [4:0] id_reg2_addr,
  input  logic       ex_is_load,
  input  logic [4:0] ex_wd,
  output logic       hazard
);

  logic match1;
  logic match2;

  assign match1 = id_reg1_read && (id_reg1_addr == ex_wd);
  assign match2 = id_reg2_read && (id_reg2_addr == ex_wd);
  // $0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = ex_is_load && (ex_wd != 5'd0) && (match1 || match2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: arbitrates flush, multi-cycle EX ops and
// load-use hazards into the per-stage stall vector, with a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg2_addr,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wd,
  input  logic             ex_mc_req,
  input  logic             ex_mc_done,
  input  logic             flush_req,
  output logic [5:0]       stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic             mc_start_o,
  output logic             mc_abort_o,
  output logic             mc_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       hazard;

  pipe_ctrl_luse u_luse (
    .id_reg1_read (id_reg1_read),
    .id_reg1_addr (id_reg1_addr),
    .id_reg2_read (id_reg2_read),
    .id_reg2_addr (id_reg2_addr),
    .ex_is_load   (ex_is_load),
    .ex_wd        (ex_wd),
    .hazard       (hazard)
  );

  // Priority: flush > multi-cycle > load-use; all outputs forced low in reset
  always_comb begin
    stall_o    = STALL_NONE;
    bubble_o   = 1'b0;
    flush_o    = 1'b0;
    mc_start_o = 1'b0;
    mc_abort_o = 1'b0;
    mc_err_o   = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (!rst) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 8'd0;
    end else if (flush_req) begin
      flush_o    = 1'b1;
      mc_abort_o = (state == ST_MC_WAIT);
      state_nxt  = ST_IDLE;
      cnt_nxt    = 8'd0;
    end else if (state == ST_MC_WAIT) begin
      // A dropped request is a completion; done beats a coincident timeout
      if (ex_mc_done || !ex_mc_req) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 8'd0;
      end else if (cnt == TO_LAST) begin
        mc_err_o   = 1'b1;
        mc_abort_o = 1'b1;
        state_nxt  = ST_IDLE;
        cnt_nxt    = 8'd0;
      end else begin
        stall_o = STALL_MC;
        cnt_nxt = cnt + 8'd1;
      end
    end else if (ex_mc_req) begin
      stall_o    = STALL_MC;
      mc_start_o = 1'b1;
      state_nxt  = ST_MC_WAIT;
      cnt_nxt    = 8'd0;
    end else if (hazard) begin
      stall_o  = STALL_LUSE;
      bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_o != STALL_NONE)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a MC_TIMEOUT=8
// instance driven by the same inputs.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_reg1_read = 1'b0;
  logic [4:0]  id_reg1_addr = 5'd0;
  logic        id_reg2_read = 1'b0;
  logic [4:0]  id_reg2_addr = 5'd0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_wd = 5'd0;
  logic        ex_mc_req = 1'b0;
  logic        ex_mc_done = 1'b0;
  logic        flush_req = 1'b0;

  logic [5:0]  stall, stall8;
  logic        bubble, bubble8, flush, flush8;
  logic        start, start8, abort, abort8, err, err8;
  logic [31:0] scnt, scnt8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wd(ex_wd),
    .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done), .flush_req(flush_req),
    .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
    .mc_start_o(start), .mc_abort_o(abort), .mc_err_o(err),
    .stall_cnt_o(scnt)
  );

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wd(ex_wd),
    .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done), .flush_req(flush_req),
    .stall_o(stall8), .bubble_o(bubble8), .flush_o(flush8),
    .mc_start_o(start8), .mc_abort_o(abort8), .mc_err_o(err8),
    .stall_cnt_o(scnt8)
  );

  task automatic clear_inputs();
    id_reg1_read = 1'b0; id_reg1_addr = 5'd0;
    id_reg2_read = 1'b0; id_reg2_addr = 5'd0;
    ex_is_load = 1'b0; ex_wd = 5'd0;
    ex_mc_req = 1'b0; ex_mc_done = 1'b0; flush_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_mc_req = 1'b1; flush_req = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd3;
    id_reg1_read = 1'b1; id_reg1_addr = 5'd3;
    #3;
    vectors++; if (stall !== 6'b000000) begin errors++; $display("FAIL rst_stall: got %b want 000000", stall); end
    vectors++; if (flush !== 1'b0 || start !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL rst_ctrl: flush=%b start=%b bubble=%b want 0", flush, start, bubble); end
    vectors++; if (scnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", scnt); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    vectors++; if (stall !== 6'b000000 || abort !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_release: stall=%b abort=%b err=%b want 0", stall, abort, err); end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_is_load = 1'b1; ex_wd = 5'd5; id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
    #1;
    vectors++; if (stall !== 6'b000111) begin errors++; $display("FAIL luse_stall: got %b want 000111", stall); end
    vectors++; if (bubble !== 1'b1) begin errors++; $display("FAIL luse_bubble: got %b want 1", bubble); end
    // load has moved on to MEM; the bubble now sits in EX
    @(negedge clk);
    ex_is_load = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000 || bubble !== 1'b0) begin errors++; $display("FAIL luse_one_cycle: stall=%b bubble=%b want 000000/0", stall, bubble); end
    vectors++; if (scnt !== 32'd1) begin errors++; $display("FAIL luse_cnt: got %0d want 1", scnt); end
    @(negedge clk);
    ex_is_load = 1'b1; ex_wd = 5'd0; id_reg2_addr = 5'd0;
    #1;
    vectors++; if (stall !== 6'b000000 || bubble !== 1'b0) begin errors++; $display("FAIL luse_r0: stall=%b bubble=%b want 000000/0", stall, bubble); end
    @(negedge clk);
    clear_inputs();
    ex_is_load = 1'b1; ex_wd = 5'd9; id_reg1_read = 1'b1; id_reg1_addr = 5'd9;
    #1;
    vectors++; if (stall !== 6'b000111 || bubble !== 1'b1) begin errors++; $display("FAIL luse_reg1: stall=%b bubble=%b want 000111/1", stall, bubble); end
    @(negedge clk);
    id_reg1_read = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000) begin errors++; $display("FAIL luse_noread: got %b want 000000", stall); end
    @(negedge clk);
    clear_inputs();
    ex_is_load = 1'b1; ex_wd = 5'd7; id_reg1_read = 1'b1; id_reg1_addr = 5'd6;
    id_reg2_read = 1'b1; id_reg2_addr = 5'd8;
    #1;
    vectors++; if (stall !== 6'b000000) begin errors++; $display("FAIL luse_nomatch: got %b want 000000", stall); end
  endtask

  task automatic test_multicycle();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    #1;
    vectors++; if (start !== 1'b1 || stall !== 6'b001111) begin errors++; $display("FAIL mc_c0: start=%b stall=%b want 1/001111", start, stall); end
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      #1;
      vectors++; if (start !== 1'b0 || stall !== 6'b001111 || err !== 1'b0) begin errors++; $display("FAIL mc_wait c%0d: start=%b stall=%b err=%b want 0/001111/0", c, start, stall, err); end
    end
    @(negedge clk);
    ex_mc_done = 1'b1;
    #1;
    vectors++; if (stall !== 6'b000000 || start !== 1'b0 || err !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL mc_done: stall=%b start=%b err=%b abort=%b want 000000/0/0/0", stall, start, err, abort); end
    vectors++; if (scnt !== 32'd34) begin errors++; $display("FAIL mc_cnt: got %0d want 34", scnt); end
    @(negedge clk);
    ex_mc_req = 1'b0; ex_mc_done = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000 || scnt !== 32'd34) begin errors++; $display("FAIL mc_after: stall=%b cnt=%0d want 000000/34", stall, scnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    #1;
    vectors++; if (start8 !== 1'b1 || stall8 !== 6'b001111) begin errors++; $display("FAIL to_start: start=%b stall=%b want 1/001111", start8, stall8); end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      #1;
      vectors++; if (stall8 !== 6'b001111 || err8 !== 1'b0 || abort8 !== 1'b0) begin errors++; $display("FAIL to_wait c%0d: stall=%b err=%b abort=%b want 001111/0/0", c, stall8, err8, abort8); end
    end
    @(negedge clk);
    #1;
    vectors++; if (err8 !== 1'b1 || abort8 !== 1'b1 || stall8 !== 6'b000000) begin errors++; $display("FAIL to_fire: err=%b abort=%b stall=%b want 1/1/000000", err8, abort8, stall8); end
    vectors++; if (scnt8 !== 32'd8) begin errors++; $display("FAIL to_cnt: got %0d want 8", scnt8); end
    @(negedge clk);
    ex_mc_req = 1'b0;
    #1;
    vectors++; if (err8 !== 1'b0 || abort8 !== 1'b0 || start8 !== 1'b0 || stall8 !== 6'b000000) begin errors++; $display("FAIL to_idle: err=%b abort=%b start=%b stall=%b want 0/0/0/000000", err8, abort8, start8, stall8); end
  endtask

  task automatic test_done_timeout();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) ex_mc_done = 1'b1;
    end
    #1;
    vectors++; if (err8 !== 1'b0 || abort8 !== 1'b0 || stall8 !== 6'b000000) begin errors++; $display("FAIL done_to: err=%b abort=%b stall=%b want 0/0/000000", err8, abort8, stall8); end
    @(negedge clk);
    ex_mc_req = 1'b0; ex_mc_done = 1'b0;
    #1;
    vectors++; if (stall8 !== 6'b000000 || err8 !== 1'b0) begin errors++; $display("FAIL done_to_idle: stall=%b err=%b want 000000/0", stall8, err8); end
  endtask

  task automatic test_req_drop();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    repeat (3) @(negedge clk);
    ex_mc_req = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000 || err !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL req_drop: stall=%b err=%b abort=%b want 000000/0/0", stall, err, abort); end
    @(negedge clk);
    ex_mc_req = 1'b1;
    #1;
    vectors++; if (start !== 1'b1) begin errors++; $display("FAIL req_drop_idle: start=%b want 1", start); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (stall !== 6'b001111) begin errors++; $display("FAIL fl_wait: got %b want 001111", stall); end
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    vectors++; if (flush !== 1'b1 || stall !== 6'b000000 || abort !== 1'b1 || bubble !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL fl_mc: flush=%b stall=%b abort=%b bubble=%b start=%b want 1/000000/1/0/0", flush, stall, abort, bubble, start); end
    @(negedge clk);
    flush_req = 1'b0; ex_mc_req = 1'b0;
    #1;
    vectors++; if (abort !== 1'b0 || stall !== 6'b000000 || flush !== 1'b0) begin errors++; $display("FAIL fl_after: abort=%b stall=%b flush=%b want 0/000000/0", abort, stall, flush); end
    @(negedge clk);
    flush_req = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd12; id_reg1_read = 1'b1; id_reg1_addr = 5'd12;
    #1;
    vectors++; if (flush !== 1'b1 || stall !== 6'b000000 || bubble !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL fl_luse: flush=%b stall=%b bubble=%b abort=%b want 1/000000/0/0", flush, stall, bubble, abort); end
    @(negedge clk);
    clear_inputs();
    flush_req = 1'b1; ex_mc_req = 1'b1;
    #1;
    vectors++; if (start !== 1'b0 || stall !== 6'b000000 || flush !== 1'b1) begin errors++; $display("FAIL fl_over_mc: start=%b stall=%b flush=%b want 0/000000/1", start, stall, flush); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    ex_mc_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (stall !== 6'b001111 || scnt !== 32'd3) begin errors++; $display("FAIL rm_pre: stall=%b cnt=%0d want 001111/3", stall, scnt); end
    rst = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000 || abort !== 1'b0 || err !== 1'b0 || start !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rm_async: stall=%b abort=%b err=%b start=%b flush=%b want all 0", stall, abort, err, start, flush); end
    vectors++; if (scnt !== 32'd0) begin errors++; $display("FAIL rm_cnt: got %0d want 0", scnt); end
    @(negedge clk);
    rst = 1'b1; ex_mc_req = 1'b0;
    #1;
    vectors++; if (stall !== 6'b000000 || abort !== 1'b0 || scnt !== 32'd0) begin errors++; $display("FAIL rm_release: stall=%b abort=%b cnt=%0d want 000000/0/0", stall, abort, scnt); end
    @(negedge clk);
    ex_mc_req = 1'b1;
    #1;
    vectors++; if (start !== 1'b1) begin errors++; $display("FAIL rm_idle: start=%b want 1", start); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_multicycle();
    test_timeout();
    test_done_timeout();
    test_req_drop();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
